fwd_hazard_unit: RTL and testbench

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_unit.sv | 94 +++++++++
 tb/tb_fwd_hazard_unit.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding select and load-use stall detection over an in-flight history
module fwd_hazard_unit #(
    parameter int REG_W    = 5,
    parameter int DEPTH    = 3,
    parameter int ALU_AGE  = 1,
    parameter int LOAD_AGE = 2,
    parameter int CNT_W    = 16,
    localparam int SEL_W   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid_in,
    input  logic [REG_W-1:0] rs1_in,
    input  logic [REG_W-1:0] rs2_in,
    input  logic [REG_W-1:0] rd_in,
    input  logic             is_load_in,
    input  logic             flush_in,
    input  logic             hold_in,
    output logic             stall_out,
    output logic             fwd1_enable_out,
    output logic [SEL_W-1:0] fwd1_sel_out,
    output logic             fwd2_enable_out,
    output logic [SEL_W-1:0] fwd2_sel_out,
    output logic [CNT_W-1:0] stall_count_out
);

    localparam logic [SEL_W-1:0] ALU_AGE_S  = SEL_W'(ALU_AGE);
    localparam logic [SEL_W-1:0] LOAD_AGE_S = SEL_W'(LOAD_AGE);

    logic [REG_W-1:0] hist_rd [DEPTH];
    logic             hist_ld [DEPTH];

    logic             hit1, hit2, ld1, ld2, ok1, ok2;
    logic [SEL_W-1:0] idx1, idx2;

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        ld1  = 1'b0;
        ld2  = 1'b0;
        idx1 = '0;
        idx2 = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (issue_valid_in && (rs1_in != '0) && (hist_rd[i] == rs1_in)) begin
                hit1 = 1'b1;
                idx1 = SEL_W'(i);
                ld1  = hist_ld[i];
            end
            if (issue_valid_in && (rs2_in != '0) && (hist_rd[i] == rs2_in)) begin
                hit2 = 1'b1;
                idx2 = SEL_W'(i);
                ld2  = hist_ld[i];
            end
        end
    end

    always_comb begin
        ok1             = hit1 && (idx1 >= (ld1 ? LOAD_AGE_S : ALU_AGE_S));
        ok2             = hit2 && (idx2 >= (ld2 ? LOAD_AGE_S : ALU_AGE_S));
        stall_out       = (hit1 && !ok1) || (hit2 && !ok2);
        fwd1_enable_out = ok1;
        fwd1_sel_out    = ok1 ? idx1 : '0;
        fwd2_enable_out = ok2;
        fwd2_sel_out    = ok2 ? idx2 : '0;
    end

    // A stalled, flushed or absent issue enters the history as a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_rd[i] <= '0;
                hist_ld[i] <= 1'b0;
            end
            stall_count_out <= '0;
        end else if (!hold_in) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                hist_rd[i] <= hist_rd[i-1];
                hist_ld[i] <= hist_ld[i-1];
            end
            if (issue_valid_in && !flush_in && !stall_out) begin
                hist_rd[0] <= rd_in;
                hist_ld[0] <= is_load_in;
            end else begin
                hist_rd[0] <= '0;
                hist_ld[0] <= 1'b0;
            end
            if (stall_out && (stall_count_out != {CNT_W{1'b1}})) begin
                stall_count_out <= stall_count_out + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

    localparam int REG_W    = 5;
    localparam int DEPTH    = 3;
    localparam int ALU_AGE  = 1;
    localparam int LOAD_AGE = 2;
    localparam int SEL_W    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid;
    logic [REG_W-1:0] rs1, rs2, rd;
    logic             is_load, flush, hold;

    logic             d_stall, d_en1, d_en2;
    logic [SEL_W-1:0] d_sel1, d_sel2;
    logic [15:0]      d_cnt;

    logic             s_stall, s_en1, s_en2;
    logic [SEL_W-1:0] s_sel1, s_sel2;
    logic [1:0]       s_cnt;

    int tests = 0;
    int fails = 0;

    int m_rd [DEPTH];
    bit m_ld [DEPTH];
    int m_cnt;
    int m_cnt2;

    bit e_stall, e_en1, e_en2;
    int e_sel1, e_sel2;

    always #5 clk = ~clk;

    fwd_hazard_unit u_dut (
        .clk(clk), .rst(rst), .issue_valid_in(issue_valid),
        .rs1_in(rs1), .rs2_in(rs2), .rd_in(rd), .is_load_in(is_load),
        .flush_in(flush), .hold_in(hold), .stall_out(d_stall),
        .fwd1_enable_out(d_en1), .fwd1_sel_out(d_sel1),
        .fwd2_enable_out(d_en2), .fwd2_sel_out(d_sel2),
        .stall_count_out(d_cnt)
    );

    fwd_hazard_unit #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .issue_valid_in(issue_valid),
        .rs1_in(rs1), .rs2_in(rs2), .rd_in(rd), .is_load_in(is_load),
        .flush_in(flush), .hold_in(hold), .stall_out(s_stall),
        .fwd1_enable_out(s_en1), .fwd1_sel_out(s_sel1),
        .fwd2_enable_out(s_en2), .fwd2_sel_out(s_sel2),
        .stall_count_out(s_cnt)
    );

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_rd[i] = 0;
            m_ld[i] = 0;
        end
        m_cnt  = 0;
        m_cnt2 = 0;
    endtask

    // Youngest producer of each source decides; it is usable once old enough for its kind.
    task automatic model_eval();
        int  src;
        int  need;
        bit  found;
        e_stall = 0; e_en1 = 0; e_en2 = 0; e_sel1 = 0; e_sel2 = 0;
        for (int s = 0; s < 2; s++) begin
            src   = (s == 0) ? int'(rs1) : int'(rs2);
            found = 0;
            for (int i = 0; i < DEPTH; i++) begin
                if (!found && issue_valid && src != 0 && m_rd[i] == src) begin
                    found = 1;
                    need  = m_ld[i] ? LOAD_AGE : ALU_AGE;
                    if (i >= need) begin
                        if (s == 0) begin e_en1 = 1; e_sel1 = i; end
                        else        begin e_en2 = 1; e_sel2 = i; end
                    end else begin
                        e_stall = 1;
                    end
                end
            end
        end
    endtask

    task automatic issue(input bit v, input int a, input int b, input int d,
                         input bit ld, input bit fl, input bit hd);
        @(negedge clk);
        issue_valid = v;
        rs1 = REG_W'(a); rs2 = REG_W'(b); rd = REG_W'(d);
        is_load = ld; flush = fl; hold = hd;
        #1;
        model_eval();
    endtask

    task automatic adv();
        @(posedge clk);
        if (!rst && !hold) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                m_rd[i] = m_rd[i-1];
                m_ld[i] = m_ld[i-1];
            end
            if (issue_valid && !flush && !e_stall) begin
                m_rd[0] = int'(rd);
                m_ld[0] = is_load;
            end else begin
                m_rd[0] = 0;
                m_ld[0] = 0;
            end
            if (e_stall) begin
                m_cnt  = (m_cnt  == 65535) ? m_cnt  : m_cnt + 1;
                m_cnt2 = (m_cnt2 == 3)     ? m_cnt2 : m_cnt2 + 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        issue_valid = 0; rs1 = 0; rs2 = 0; rd = 0; is_load = 0; flush = 0; hold = 0;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        issue_valid = 1; rs1 = 1; rs2 = 2; rd = 3; is_load = 0; flush = 0; hold = 0;
        #2;
        tests++;
        if ({d_stall, d_en1, d_en2} !== 3'b000 || d_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_outputs: got stall=%b en=%b%b cnt=%0d, want 0 0 0 0", d_stall, d_en1, d_en2, d_cnt);
        end
        do_reset();
    endtask

    task automatic test_alu_use();
        do_reset();
        issue(1, 0, 0, 5, 0, 0, 0);
        adv();
        issue(1, 5, 0, 0, 0, 0, 0);
        tests++;
        if (d_stall !== 1'b1 || d_en1 !== 1'b0) begin
            fails++;
            $display("FAIL alu_use_stall: got stall=%b en1=%b, want 1 0", d_stall, d_en1);
        end
        adv();
        issue(1, 5, 0, 0, 0, 0, 0);
        tests++;
        if (d_stall !== 1'b0 || d_en1 !== 1'b1 || d_sel1 !== 2'd1 || d_cnt !== 16'd1) begin
            fails++;
            $display("FAIL alu_use_fwd: got stall=%b en1=%b sel1=%0d cnt=%0d, want 0 1 1 1", d_stall, d_en1, d_sel1, d_cnt);
        end
        adv();
    endtask

    task automatic test_load_use();
        do_reset();
        issue(1, 0, 0, 6, 1, 0, 0);
        adv();
        for (int k = 0; k < 2; k++) begin
            issue(1, 0, 6, 0, 0, 0, 0);
            tests++;
            if (d_stall !== 1'b1 || d_en2 !== 1'b0) begin
                fails++;
                $display("FAIL load_use_stall%0d: got stall=%b en2=%b, want 1 0", k, d_stall, d_en2);
            end
            adv();
        end
        issue(1, 0, 6, 0, 0, 0, 0);
        tests++;
        if (d_stall !== 1'b0 || d_en2 !== 1'b1 || d_sel2 !== 2'd2 || d_cnt !== 16'd2) begin
            fails++;
            $display("FAIL load_use_fwd: got stall=%b en2=%b sel2=%0d cnt=%0d, want 0 1 2 2", d_stall, d_en2, d_sel2, d_cnt);
        end
        adv();
    endtask

    task automatic test_back_to_back();
        do_reset();
        issue(1, 0, 0, 7, 0, 0, 0); adv();
        issue(1, 0, 0, 7, 0, 0, 0); adv();
        issue(1, 0, 0, 0, 0, 0, 0); adv();
        issue(1, 7, 0, 0, 0, 0, 0);
        tests++;
        if (d_stall !== 1'b0 || d_en1 !== 1'b1 || d_sel1 !== 2'd1) begin
            fails++;
            $display("FAIL back_to_back: got stall=%b en1=%b sel1=%0d, want 0 1 1", d_stall, d_en1, d_sel1);
        end
        adv();
    endtask

    task automatic test_flush();
        do_reset();
        issue(1, 0, 0, 8, 0, 1, 0); adv();
        issue(1, 8, 0, 0, 0, 0, 0);
        tests++;
        if (d_stall !== 1'b0 || d_en1 !== 1'b0 || d_sel1 !== 2'd0) begin
            fails++;
            $display("FAIL flush_bubble: got stall=%b en1=%b sel1=%0d, want 0 0 0", d_stall, d_en1, d_sel1);
        end
        adv();
    endtask

    task automatic test_hold();
        do_reset();
        issue(1, 0, 0, 6, 1, 0, 0); adv();
        issue(1, 0, 6, 0, 0, 0, 0); adv();
        for (int k = 0; k < 3; k++) begin
            issue(1, 0, 6, 0, 0, 0, 1);
            tests++;
            if (d_stall !== 1'b1 || d_cnt !== 16'd1) begin
                fails++;
                $display("FAIL hold_frozen%0d: got stall=%b cnt=%0d, want 1 1", k, d_stall, d_cnt);
            end
            adv();
        end
        issue(1, 0, 6, 0, 0, 0, 0);
        tests++;
        if (d_stall !== 1'b1 || d_cnt !== 16'd1) begin
            fails++;
            $display("FAIL hold_release: got stall=%b cnt=%0d, want 1 1", d_stall, d_cnt);
        end
        adv();
        issue(1, 0, 6, 0, 0, 0, 0);
        tests++;
        if (d_stall !== 1'b0 || d_en2 !== 1'b1 || d_sel2 !== 2'd2 || d_cnt !== 16'd2) begin
            fails++;
            $display("FAIL hold_resume: got stall=%b en2=%b sel2=%0d cnt=%0d, want 0 1 2 2", d_stall, d_en2, d_sel2, d_cnt);
        end
        adv();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        issue(1, 0, 0, 6, 1, 0, 0); adv();
        issue(1, 0, 6, 0, 0, 0, 0); adv();
        issue(1, 0, 6, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        tests++;
        if ({d_stall, d_en1, d_en2} !== 3'b000 || d_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_mid_stall: got stall=%b en=%b%b cnt=%0d, want 0 0 0 0", d_stall, d_en1, d_en2, d_cnt);
        end
        model_clear();
        #1;
        rst = 1'b0;
        model_eval();
        adv();
        issue(1, 0, 6, 0, 0, 0, 0);
        tests++;
        if (d_stall !== 1'b0 || d_en2 !== 1'b0 || d_cnt !== 16'd0) begin
            fails++;
            $display("FAIL reset_after: got stall=%b en2=%b cnt=%0d, want 0 0 0", d_stall, d_en2, d_cnt);
        end
        adv();
    endtask

    task automatic test_saturate();
        int n;
        do_reset();
        n = 0;
        for (int k = 0; k < 3; k++) begin
            issue(1, 0, 0, 10 + k, 1, 0, 0); adv();
            for (int j = 0; j < 2; j++) begin
                issue(1, 10 + k, 0, 0, 0, 0, 0); adv();
                n++;
                tests++;
                if (s_cnt !== 2'((n > 3) ? 3 : n) || d_cnt !== 16'(n)) begin
                    fails++;
                    $display("FAIL saturate_n%0d: got sat=%0d wide=%0d, want %0d %0d", n, s_cnt, d_cnt, (n > 3) ? 3 : n, n);
                end
            end
            issue(1, 10 + k, 0, 0, 0, 0, 0); adv();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            issue($urandom_range(9, 0) != 0, $urandom_range(3, 0), $urandom_range(3, 0),
                  $urandom_range(3, 0), $urandom_range(2, 0) == 0,
                  $urandom_range(7, 0) == 0, $urandom_range(9, 0) == 0);
            tests++;
            if (d_stall !== e_stall || d_en1 !== e_en1 || d_en2 !== e_en2 ||
                d_sel1 !== SEL_W'(e_sel1) || d_sel2 !== SEL_W'(e_sel2) ||
                s_stall !== e_stall || s_en1 !== e_en1 || s_en2 !== e_en2 ||
                s_sel1 !== SEL_W'(e_sel1) || s_sel2 !== SEL_W'(e_sel2)) begin
                fails++;
                $display("FAIL random_c%0d: got stall=%b en=%b%b sel=%0d,%0d, want %b %b%b %0d,%0d",
                         c, d_stall, d_en1, d_en2, d_sel1, d_sel2, e_stall, e_en1, e_en2, e_sel1, e_sel2);
            end
            tests++;
            if (d_cnt !== 16'(m_cnt) || s_cnt !== 2'(m_cnt2)) begin
                fails++;
                $display("FAIL random_cnt_c%0d: got %0d/%0d, want %0d/%0d", c, d_cnt, s_cnt, m_cnt, m_cnt2);
            end
            adv();
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_alu_use();
        test_load_use();
        test_back_to_back();
        test_flush();
        test_hold();
        test_reset_mid_stall();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
